// File: rtl/cycle_watchdog_pkg.sv
// Shared types and defaults for the cycle watchdog.
// Optional early-warning output is enabled with CYCLE_WATCHDOG_WARN_EN.
package cycle_watchdog_pkg;

    localparam int CNT_W_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } wd_state_t;

endpackage

// File: rtl/cycle_watchdog_if.sv
// Control/status bundle of the cycle watchdog; master drives, watchdog is the slave.
// warn_thresh/warn exist only when CYCLE_WATCHDOG_WARN_EN is defined.
interface cycle_watchdog_if
    import cycle_watchdog_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
);
    logic             enable;
    logic             kick;
    logic [CNT_W-1:0] limit;
    logic [CNT_W-1:0] count;
    logic             expired;
    logic             timeout;
    logic             busy;
`ifdef CYCLE_WATCHDOG_WARN_EN
    logic [CNT_W-1:0] warn_thresh;
    logic             warn;
`endif

    modport master (
        output enable, kick, limit,
`ifdef CYCLE_WATCHDOG_WARN_EN
        output warn_thresh,
        input  warn,
`endif
        input  count, expired, timeout, busy
    );

    modport slave (
        input  enable, kick, limit,
`ifdef CYCLE_WATCHDOG_WARN_EN
        input  warn_thresh,
        output warn,
`endif
        output count, expired, timeout, busy
    );

endinterface

// File: rtl/cycle_watchdog.sv
// Cycle watchdog: counts cycles while armed, expires at count >= limit, restarted by kick.
// Define CYCLE_WATCHDOG_WARN_EN to add the registered early-warning output.
module cycle_watchdog
    import cycle_watchdog_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input logic             clk,
    input logic             rst,
    cycle_watchdog_if.slave wd
);

    wd_state_t        state;
    wd_state_t        next_state;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] next_count;
    logic             fire;

    // Disarm beats kick and expiry; kick beats expiry inside RUN.
    // The count cannot wrap: at all-ones, count >= limit holds for any limit.
    always_comb begin
        next_state = state;
        next_count = count;
        fire       = 1'b0;
        if (!wd.enable) begin
            next_state = IDLE;
            next_count = '0;
        end else begin
            case (state)
                IDLE: begin
                    next_state = RUN;
                    next_count = '0;
                end
                RUN: begin
                    if (wd.kick) begin
                        next_count = '0;
                    end else if (count >= wd.limit) begin
                        next_state = EXPIRED;
                        fire       = 1'b1;
                    end else begin
                        next_count = count + CNT_W'(1);
                    end
                end
                EXPIRED: begin
                    if (wd.kick) begin
                        next_state = RUN;
                        next_count = '0;
                    end
                end
                default: begin
                    next_state = IDLE;
                    next_count = '0;
                end
            endcase
        end
    end

    // Outputs are registered from next-state values so they line up with the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            wd.expired <= 1'b0;
            wd.timeout <= 1'b0;
            wd.busy    <= 1'b0;
`ifdef CYCLE_WATCHDOG_WARN_EN
            wd.warn    <= 1'b0;
`endif
        end else begin
            state      <= next_state;
            count      <= next_count;
            wd.expired <= (next_state == EXPIRED);
            wd.timeout <= fire;
            wd.busy    <= (next_state == RUN);
`ifdef CYCLE_WATCHDOG_WARN_EN
            wd.warn    <= (next_state == RUN) && (next_count >= wd.warn_thresh);
`endif
        end
    end

    assign wd.count = count;

endmodule

// File: doc/cycle_watchdog.md
CYCLE_WATCHDOG -- requirements
Module: cycle_watchdog

Interface
REQ-001 Parameter CNT_W, default 32, width of counter, limit and threshold values.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  synchronous active-high reset, sampled on posedge clk.
REQ-004 enable  input  1  level; 1 = watchdog armed, 0 = disarmed.
REQ-005 kick  input  1  single-cycle restart request; clears the running count.
REQ-006 limit  input  CNT_W  timeout value in clk cycles, unsigned.
REQ-007 count  output  CNT_W  current elapsed cycles since arm or last kick.
REQ-008 expired  output  1  level; 1 while in EXPIRED state.
REQ-009 timeout  output  1  one-cycle pulse on entry to EXPIRED.
REQ-010 busy  output  1  1 while in RUN state.

Function
REQ-011 FSM states IDLE, RUN, EXPIRED; all outputs registered, no combinational input-to-output path.
REQ-012 IDLE: count = 0; enable = 1 -> RUN next cycle with count = 0.
REQ-013 RUN: count increments by 1 each cycle; busy = 1.
REQ-014 RUN with kick = 1 -> count = 0 next cycle, remain RUN.
REQ-015 RUN with count >= limit and kick = 0 -> EXPIRED next cycle, timeout = 1 for that single cycle, count holds.
REQ-016 Compare is unsigned >=, so lowering limit below count mid-run expires on the next cycle.
REQ-017 limit = 0: expiry one cycle after entering RUN.
REQ-018 count never wraps; max reachable value is 2^CNT_W-1, where limit = all-ones still expires.
REQ-019 EXPIRED: expired = 1, count frozen; kick = 1 -> RUN with count = 0, expired drops next cycle.
REQ-020 enable = 0 in any state -> IDLE next cycle, count = 0; enable = 0 takes priority over kick and expiry.
REQ-021 Simultaneous kick and count >= limit in RUN: kick wins, no timeout pulse.
REQ-022 kick in IDLE is ignored.

Reset
REQ-023 rst = 1 -> next cycle state IDLE, count = 0, expired = 0, timeout = 0, busy = 0 (warn = 0 when present).
REQ-024 rst overrides enable, kick and expiry; asserting rst mid-RUN or in EXPIRED discards the count and pending timeout.
REQ-025 First enable sampled one cycle after rst deasserts starts RUN normally.

Configuration
REQ-026 Macro CYCLE_WATCHDOG_WARN_EN compiles in an early-warning feature.
REQ-027 With macro: extra input warn_thresh (CNT_W) and output warn (1); warn = 1 registered while in RUN and count >= warn_thresh; 0 in IDLE and EXPIRED.
REQ-028 Without macro: warn_thresh and warn ports absent; all other behaviour identical.

Structure
REQ-029 Package cycle_watchdog_pkg holds the state enum typedef (IDLE, RUN, EXPIRED) and the default CNT_W constant.
REQ-030 Single module, no sub-module; counter and FSM in one file.

Verification
REQ-031 rst 3 cycles, enable = 1, limit = 10 -> busy from cycle 1, count reaches 10, timeout pulses once, expired = 1, count frozen at 10.
REQ-032 limit = 10, kick at count = 6 -> count = 0 next cycle, expiry occurs 10 cycles after the kick, not before.
REQ-033 kick in the same cycle as count = limit = 5 -> no timeout, count = 0, state RUN.
REQ-034 In EXPIRED with enable = 0 -> IDLE, count = 0, expired = 0; re-enable, limit = 0 -> timeout one cycle after RUN entry.
REQ-035 rst asserted at count = 7 with limit = 8 -> no timeout ever, all outputs 0 next cycle.
REQ-036 With CYCLE_WATCHDOG_WARN_EN, warn_thresh = 4, limit = 8 -> warn rises at count = 4, stays 1 to count = 8, drops on entry to EXPIRED.
